fetch_sequencer: RTL and testbench

//  Program-counter owner and instruction sequencer for the 16-bit core.

---
 rtl/fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_sequencer_cc_unit.sv | 21 ++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encodings, opcodes and defaults for fetch_sequencer
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0]  OP_BR        = 4'hC;
  localparam logic [3:0]  OP_JMP       = 4'hD;
  localparam logic [3:0]  OP_TRAP      = 4'hF;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  // Top nibble of the instruction selects the opcode class
  function automatic logic is_trap(input logic [3:0] op_nibble);
    return op_nibble == OP_TRAP;
  endfunction

endpackage

// File: rtl/fetch_sequencer_cc_unit.sv
// rtl/fetch_sequencer_cc_unit.sv - combinational n/z/p decode of a datapath result
module cc_unit #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_result,
  output logic              o_n,
  output logic              o_z,
  output logic              o_p
);

  logic w_zero;

  // Exactly one of n/z/p is set for any result value
  always_comb begin
    w_zero = (i_result == '0);
    o_n    = i_result[DATA_W-1];
    o_z    = w_zero;
    o_p    = !i_result[DATA_W-1] && !w_zero;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/IR/CC owner and fetch-execute-commit sequencer (option: HALT_DETECT_EN)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ip,
  output logic [DATA_W-1:0] opcode,
  output logic              n,
  output logic              z,
  output logic              p,
  input  logic [DATA_W-1:0] next_ip,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              cc_we,
  input  logic [DATA_W-1:0] cc_result,
  output logic              halted
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_exec_first;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_n;
  logic              r_z;
  logic              r_p;
  logic              w_n;
  logic              w_z;
  logic              w_p;
`ifdef HALT_DETECT_EN
  logic              w_trap;

  assign w_trap = is_trap(r_ir[DATA_W-1 -: 4]);
`endif

  cc_unit #(.DATA_W(DATA_W)) u_cc_unit (
    .i_result (cc_result),
    .o_n      (w_n),
    .o_z      (w_z),
    .o_p      (w_p)
  );

  // State register; reset aborts any in-flight fetch or execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: strays (ack outside FETCH, done outside EXEC) fall through unchanged
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = ST_FETCH;
      ST_FETCH:  if (imem_ack) w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
`ifdef HALT_DETECT_EN
          w_next_state = w_trap ? ST_HALT : ST_COMMIT;
`else
          w_next_state = ST_COMMIT;
`endif
        end
      end
      ST_COMMIT: w_next_state = ST_FETCH;
      ST_HALT:   w_next_state = ST_HALT;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // PC, IR, CC and first-EXEC-cycle flag; CC lands before COMMIT so next_ip sees new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_n          <= 1'b0;
      r_z          <= 1'b1;
      r_p          <= 1'b0;
      r_exec_first <= 1'b0;
    end else begin
      r_exec_first <= (r_state == ST_FETCH) && imem_ack;
      if ((r_state == ST_FETCH) && imem_ack)
        r_ir <= imem_rdata;
      if ((r_state == ST_EXEC) && exec_done && cc_we) begin
        r_n <= w_n;
        r_z <= w_z;
        r_p <= w_p;
      end
      if (r_state == ST_COMMIT)
        r_pc <= next_ip;
    end
  end

  // Outputs decoded from state; held registers drive the next-IP interface
  always_comb begin
    imem_req   = (r_state == ST_FETCH);
    exec_start = (r_state == ST_EXEC) && r_exec_first;
`ifdef HALT_DETECT_EN
    halted     = (r_state == ST_HALT);
`else
    halted     = 1'b0;
`endif
    imem_addr  = r_pc;
    ip         = r_pc;
    opcode     = r_ir;
    n          = r_n;
    z          = r_z;
    p          = r_p;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer (honours HALT_DETECT_EN)
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ip;
  logic [15:0] opcode;
  logic        n, z, p;
  logic [15:0] next_ip;
  logic        exec_start;
  logic        exec_done;
  logic        cc_we;
  logic [15:0] cc_result;
  logic        halted;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_pc;
  logic [2:0]  m_nzp;
  bit          m_halted;

  typedef struct {
    logic [15:0] rdata;
    int          ack_wait;
    int          done_wait;
    bit          we;
    logic [15:0] res;
    logic [15:0] nip;
    logic [2:0]  exp_nzp;
    logic [15:0] exp_next_addr;
  } vec_t;

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ip         (ip),
    .opcode     (opcode),
    .n          (n),
    .z          (z),
    .p          (p),
    .next_ip    (next_ip),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .cc_we      (cc_we),
    .cc_result  (cc_result),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_nzp(input logic [15:0] res);
    if (res == 16'd0)          return 3'b010;
    else if ($signed(res) < 0) return 3'b100;
    else                       return 3'b001;
  endfunction

  function automatic bit ref_halts(input logic [15:0] instr);
`ifdef HALT_DETECT_EN
    return instr[15:12] == 4'hF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_inputs();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    exec_done  = 1'b0;
    cc_we      = 1'b0;
    cc_result  = 16'h0;
    next_ip    = 16'h0;
  endtask

  // Hold reset, check reset values, release at a falling edge and step into FETCH
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("rst_req",    {31'd0, imem_req},   0);
    chk("rst_start",  {31'd0, exec_start}, 0);
    chk("rst_halted", {31'd0, halted},     0);
    chk("rst_ip",     {16'd0, ip},         0);
    chk("rst_ir",     {16'd0, opcode},     0);
    chk("rst_nzp",    {29'd0, n, z, p},    32'b010);
    rst_n = 1'b1;
    chk("idle_req",   {31'd0, imem_req},   0);
    @(negedge clk);
    m_pc     = 16'h0000;
    m_nzp    = 3'b010;
    m_halted = 1'b0;
  endtask

  // Play imem and datapath for one instruction; entered and left on a FETCH-cycle falling edge
  task automatic run_instr(input logic [15:0] rdata, input int ack_wait, input int done_wait,
                           input bit we, input logic [15:0] res, input logic [15:0] nip);
    bit hlt;
    hlt = ref_halts(rdata);
    for (int i = 0; i <= ack_wait; i++) begin
      chk("fetch_req",   {31'd0, imem_req},   1);
      chk("fetch_addr",  {16'd0, imem_addr},  {16'd0, m_pc});
      chk("fetch_start", {31'd0, exec_start}, 0);
      imem_ack   = (i == ack_wait);
      imem_rdata = (i == ack_wait) ? rdata : 16'($urandom);
      exec_done  = 1'($urandom);
      cc_we      = 1'b1;
      cc_result  = 16'($urandom);
      @(negedge clk);
    end
    for (int j = 0; j <= done_wait; j++) begin
      chk("exec_start",  {31'd0, exec_start}, (j == 0) ? 32'd1 : 32'd0);
      chk("exec_req",    {31'd0, imem_req},   0);
      chk("exec_ir",     {16'd0, opcode},     {16'd0, rdata});
      chk("exec_ip",     {16'd0, ip},         {16'd0, m_pc});
      chk("exec_nzp",    {29'd0, n, z, p},    {29'd0, m_nzp});
      imem_ack   = 1'($urandom);
      imem_rdata = 16'($urandom);
      exec_done  = (j == done_wait);
      cc_we      = (j == done_wait) ? we : 1'($urandom);
      cc_result  = (j == done_wait) ? res : 16'($urandom);
      @(negedge clk);
    end
    if (we) m_nzp = ref_nzp(res);
    imem_ack  = 1'b0;
    cc_we     = 1'b0;
    exec_done = 1'($urandom);
    chk("post_nzp", {29'd0, n, z, p}, {29'd0, m_nzp});
    chk("post_ip",  {16'd0, ip},      {16'd0, m_pc});
    chk("post_ir",  {16'd0, opcode},  {16'd0, rdata});
    if (hlt) begin
      for (int k = 0; k < 4; k++) begin
        chk("halt_flag", {31'd0, halted},   1);
        chk("halt_req",  {31'd0, imem_req}, 0);
        imem_ack = 1'($urandom);
        @(negedge clk);
      end
      m_halted = 1'b1;
    end else begin
      chk("commit_halted", {31'd0, halted},     0);
      chk("commit_start",  {31'd0, exec_start}, 0);
      next_ip = nip;
      imem_ack = 1'($urandom);
      @(negedge clk);
      m_pc = nip;
    end
    clear_inputs();
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'h1234, 0, 0, 1'b1, 16'h8000, 16'h0001, 3'b100, 16'h0001};
    vecs[1] = '{16'h5678, 3, 0, 1'b1, 16'h0000, 16'h0002, 3'b010, 16'h0002};
    vecs[2] = '{16'h9ABC, 0, 2, 1'b1, 16'h0001, 16'hFFFF, 3'b001, 16'hFFFF};
    vecs[3] = '{16'hC001, 1, 1, 1'b0, 16'h8000, 16'h0000, 3'b001, 16'h0000};
    vecs[4] = '{16'hD00F, 0, 0, 1'b1, 16'hFFFF, 16'h0100, 3'b100, 16'h0100};
    vecs[5] = '{16'h0000, 2, 3, 1'b1, 16'h7FFF, 16'h0101, 3'b001, 16'h0101};

    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 0);
    do_reset();

    for (int v = 0; v < 6; v++) begin
      run_instr(vecs[v].rdata, vecs[v].ack_wait, vecs[v].done_wait,
                vecs[v].we, vecs[v].res, vecs[v].nip);
      chk("tbl_nzp",  {29'd0, n, z, p},   {29'd0, vecs[v].exp_nzp});
      chk("tbl_addr", {16'd0, imem_addr}, {16'd0, vecs[v].exp_next_addr});
    end

    imem_ack   = 1'b1;
    imem_rdata = 16'hABCD;
    @(negedge clk);
    clear_inputs();
    chk("pre_rst_start", {31'd0, exec_start}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc",    {16'd0, ip},         0);
    chk("mid_rst_nzp",   {29'd0, n, z, p},    32'b010);
    chk("mid_rst_req",   {31'd0, imem_req},   0);
    chk("mid_rst_start", {31'd0, exec_start}, 0);
    do_reset();

    for (int r = 0; r < 40; r++) begin
      logic [15:0] instr;
      instr = 16'($urandom);
      if (instr[15:12] == 4'hF) instr[15:12] = 4'hE;
      run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 16'($urandom), 16'($urandom));
    end

    run_instr(16'hF025, 0, 1, 1'b1, 16'h0000, 16'h4242);
    if (m_halted) begin
      do_reset();
    end else begin
      chk("trap_next_addr", {16'd0, imem_addr}, 32'h4242);
    end
    run_instr(16'h1111, 1, 0, 1'b1, 16'h8001, 16'h0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
